// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: display-mode encodings and the digit and lap-entry widths.
package stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam int LAP_W = 16;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'b00,
        MODE_FROZEN = 2'b01,
        MODE_RECALL = 2'b10
    } mode_t;

endpackage

// File: rtl/lap_regfile.sv
// Lap storage: DEPTH x LAP_W register array, one synchronous write port, one combinational read port.
module lap_regfile
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [LAP_W-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [LAP_W-1:0] rdata
);

    // Contents are meaningless until counted valid by the parent, so no reset.
    logic [LAP_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_recall_buffer.sv
// Lap capture / freeze / recall stage between time_core and display_mux.
// Build option: define LAP_OVERWRITE_EN to let a lap on a full buffer overwrite the oldest entry.
module lap_recall_buffer
    import stopwatch_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int HOLD_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             lap_pulse,
    input  logic             recall_pulse,
    input  logic             clear_pulse,
    input  logic [BCD_W-1:0] mt_in,
    input  logic [BCD_W-1:0] mo_in,
    input  logic [BCD_W-1:0] st_in,
    input  logic [BCD_W-1:0] so_in,
    output logic [BCD_W-1:0] mt_out,
    output logic [BCD_W-1:0] mo_out,
    output logic [BCD_W-1:0] st_out,
    output logic [BCD_W-1:0] so_out,
    output logic [PTR_W:0]   lap_count,
    output logic [PTR_W-1:0] recall_idx,
    output logic [1:0]       mode,
    output logic             buf_full
);

`ifdef LAP_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    mode_t             mode_q, mode_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [PTR_W:0]    count_q, count_n;
    logic [PTR_W-1:0]  idx_q, idx_n;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n;
    logic              we;
    logic              overwrite;
    logic              full_q;
    logic [LAP_W-1:0]  live_word;
    logic [LAP_W-1:0]  rd_word;
    logic [LAP_W-1:0]  shown_word;
    logic [LAP_W-1:0]  disp_n;
    logic [PTR_W-1:0]  raddr;

    assign full_q    = (count_q == CNT_FULL);
    assign live_word = {mt_in, mo_in, st_in, so_in};

    always_comb begin
        mode_n    = mode_q;
        hold_n    = hold_q;
        count_n   = count_q;
        idx_n     = idx_q;
        wr_ptr_n  = wr_ptr_q;
        we        = 1'b0;
        overwrite = 1'b0;

        if (clear_pulse) begin
            mode_n  = MODE_LIVE;
            hold_n  = '0;
            count_n = '0;
            idx_n   = '0;
        end else if (lap_pulse) begin
            if (!full_q) begin
                we      = 1'b1;
                count_n = count_q + CNT_ONE;
            end else if (OVERWRITE) begin
                we        = 1'b1;
                overwrite = 1'b1;
            end
            if (we) begin
                wr_ptr_n = wr_ptr_q + PTR_ONE;
                if (mode_q == MODE_RECALL) begin
                    // Keep pointing at the same lap after the oldest one slides out.
                    if (overwrite && idx_q != '0) begin
                        idx_n = idx_q - PTR_ONE;
                    end
                end else begin
                    mode_n = MODE_FROZEN;
                    hold_n = HOLD_LOAD;
                end
            end
        end else if (recall_pulse) begin
            if (mode_q == MODE_RECALL) begin
                if ({1'b0, idx_q} == count_q - CNT_ONE) begin
                    mode_n = MODE_LIVE;
                    idx_n  = '0;
                end else begin
                    idx_n = idx_q + PTR_ONE;
                end
            end else if (count_q != '0) begin
                mode_n = MODE_RECALL;
                idx_n  = '0;
                hold_n = '0;
            end
        end else if (tick_1hz && mode_q == MODE_FROZEN) begin
            if (hold_q <= HOLD_ONE) begin
                mode_n = MODE_LIVE;
                hold_n = '0;
            end else begin
                hold_n = hold_q - HOLD_ONE;
            end
        end
    end

    // The display register follows the next state, so the read address is built from
    // next-state pointers; an entry written this same cycle is forwarded from the inputs.
    always_comb begin
        if (mode_n == MODE_RECALL) begin
            raddr = wr_ptr_n - count_n[PTR_W-1:0] + idx_n;
        end else begin
            raddr = wr_ptr_n - PTR_ONE;
        end
    end

    assign shown_word = (we && raddr == wr_ptr_q) ? live_word : rd_word;
    assign disp_n     = (mode_n == MODE_LIVE) ? live_word : shown_word;

    lap_regfile #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (live_word),
        .raddr (raddr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_LIVE;
            hold_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            buf_full   <= 1'b0;
            mt_out     <= '0;
            mo_out     <= '0;
            st_out     <= '0;
            so_out     <= '0;
        end else begin
            mode_q     <= mode_n;
            hold_q     <= hold_n;
            count_q    <= count_n;
            idx_q      <= idx_n;
            wr_ptr_q   <= wr_ptr_n;
            buf_full   <= (count_n == CNT_FULL);
            mt_out     <= disp_n[15:12];
            mo_out     <= disp_n[11:8];
            st_out     <= disp_n[7:4];
            so_out     <= disp_n[3:0];
        end
    end

    assign mode       = mode_q;
    assign lap_count  = count_q;
    assign recall_idx = idx_q;

endmodule

// File: tb/tb_lap_recall_buffer.sv
// Directed bench for lap_recall_buffer: driver pushes expected {mode,count,idx,full,digits}, monitor checks.
module tb_lap_recall_buffer;

    localparam logic [1:0] M_L = 2'b00;
    localparam logic [1:0] M_F = 2'b01;
    localparam logic [1:0] M_R = 2'b10;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       lap_pulse;
    logic       recall_pulse;
    logic       clear_pulse;
    logic [3:0] mt_in, mo_in, st_in, so_in;
    logic [3:0] mt_out, mo_out, st_out, so_out;
    logic [2:0] lap_count;
    logic [1:0] recall_idx;
    logic [1:0] mode;
    logic       buf_full;

    lap_recall_buffer #(
        .DEPTH      (4),
        .PTR_W      (2),
        .HOLD_TICKS (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .lap_pulse    (lap_pulse),
        .recall_pulse (recall_pulse),
        .clear_pulse  (clear_pulse),
        .mt_in        (mt_in),
        .mo_in        (mo_in),
        .st_in        (st_in),
        .so_in        (so_in),
        .mt_out       (mt_out),
        .mo_out       (mo_out),
        .st_out       (st_out),
        .so_out       (so_out),
        .lap_count    (lap_count),
        .recall_idx   (recall_idx),
        .mode         (mode),
        .buf_full     (buf_full)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [23:0] exp_q[$];
    int          tgt_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [23:0] ex(input logic [1:0] m, input logic [2:0] c,
                                       input logic [1:0] i, input logic f,
                                       input logic [15:0] d);
        return {m, c, i, f, d};
    endfunction

    // driver: one call = one clock of stimulus; expectation is for the state after that edge
    task automatic step(input string nm, input logic r, input logic lp, input logic rc,
                        input logic cl, input logic tk, input logic [15:0] lv,
                        input logic chk, input logic [23:0] e);
        @(negedge clk);
        rst          = r;
        lap_pulse    = lp;
        recall_pulse = rc;
        clear_pulse  = cl;
        tick_1hz     = tk;
        {mt_in, mo_in, st_in, so_in} = lv;
        if (chk) begin
            exp_q.push_back(e);
            tgt_q.push_back(cyc + 1);
            name_q.push_back(nm);
        end
    endtask

    // monitor
    logic [23:0] m_exp;
    logic [23:0] m_got;
    int          m_tgt;
    string       m_name;
    always @(posedge clk) begin
        #1;
        while (tgt_q.size() > 0 && tgt_q[0] <= cyc) begin
            m_exp  = exp_q.pop_front();
            m_tgt  = tgt_q.pop_front();
            m_name = name_q.pop_front();
            m_got  = {mode, lap_count, recall_idx, buf_full, mt_out, mo_out, st_out, so_out};
            n_tests++;
            if (m_tgt != cyc || m_got !== m_exp) begin
                n_fail++;
                $display("FAIL %s: got mode/cnt/idx/full/digits=%h expected %h (cycle %0d target %0d)",
                         m_name, m_got, m_exp, cyc, m_tgt);
            end
        end
    end

    initial begin
        rst = 1'b1; lap_pulse = 1'b0; recall_pulse = 1'b0; clear_pulse = 1'b0; tick_1hz = 1'b0;
        {mt_in, mo_in, st_in, so_in} = 16'h0000;

        step("reset",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0000));
        step("live_1234",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h1234));
        step("lap_0005",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0005));
        step("frozen_hold",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0005));
        step("tick1",        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0005));
        step("tick2",        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0005));
        step("tick3_live",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0009, 1'b1, ex(M_L, 3'd1, 2'd0, 1'b0, 16'h0009));
        step("clear",        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0010));

        step("lap_a1",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0001));
        step("lap_a2",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, ex(M_F, 3'd2, 2'd0, 1'b0, 16'h0002));
        step("lap_a3",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, ex(M_F, 3'd3, 2'd0, 1'b0, 16'h0003));
        step("recall_0",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0099, 1'b1, ex(M_R, 3'd3, 2'd0, 1'b0, 16'h0001));
        step("recall_1",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0099, 1'b1, ex(M_R, 3'd3, 2'd1, 1'b0, 16'h0002));
        step("recall_2",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0099, 1'b1, ex(M_R, 3'd3, 2'd2, 1'b0, 16'h0003));
        step("recall_wrap",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0099, 1'b1, ex(M_L, 3'd3, 2'd0, 1'b0, 16'h0099));
        step("clear2",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0000));

        step("fill_1",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0001));
        step("fill_2",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, ex(M_F, 3'd2, 2'd0, 1'b0, 16'h0002));
        step("fill_3",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, ex(M_F, 3'd3, 2'd0, 1'b0, 16'h0003));
        step("fill_4",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, ex(M_F, 3'd4, 2'd0, 1'b1, 16'h0004));
        step("full_tick1",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, ex(M_F, 3'd4, 2'd0, 1'b1, 16'h0004));
        step("full_tick2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 24'h0);
        step("full_live",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, ex(M_L, 3'd4, 2'd0, 1'b1, 16'h0000));
`ifdef LAP_OVERWRITE_EN
        step("lap_full",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, ex(M_F, 3'd4, 2'd0, 1'b1, 16'h0005));
        step("full_rec_0",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, ex(M_R, 3'd4, 2'd0, 1'b1, 16'h0002));
        step("full_rec_1",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, ex(M_R, 3'd4, 2'd1, 1'b1, 16'h0003));
        step("lap_in_rec",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, ex(M_R, 3'd4, 2'd0, 1'b1, 16'h0003));
`else
        step("lap_full",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, ex(M_L, 3'd4, 2'd0, 1'b1, 16'h0005));
        step("full_rec_0",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, ex(M_R, 3'd4, 2'd0, 1'b1, 16'h0001));
        step("full_rec_1",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, ex(M_R, 3'd4, 2'd1, 1'b1, 16'h0002));
        step("lap_in_rec",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, ex(M_R, 3'd4, 2'd1, 1'b1, 16'h0002));
`endif
        step("clear_rec",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0000));

        step("lap_and_rec",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0042));
        step("clear_and_lap",1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0043, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0043));
        step("recall_empty", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0044, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0044));
        step("lap_0050",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b1, ex(M_F, 3'd1, 2'd0, 1'b0, 16'h0050));
        step("recall_one",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0051, 1'b1, ex(M_R, 3'd1, 2'd0, 1'b0, 16'h0050));
        step("lap_rec_grow", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 1'b1, ex(M_R, 3'd2, 2'd0, 1'b0, 16'h0050));
        step("recall_next",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0061, 1'b1, ex(M_R, 3'd2, 2'd1, 1'b0, 16'h0060));
        step("rst_in_rec",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0062, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0000));
        step("live_post_rst",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0063, 1'b1, ex(M_L, 3'd0, 2'd0, 1'b0, 16'h0063));
        step("idle",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 24'h0);

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
